// File: rtl/serial_mag_comp_ctrl.sv
// Bit-serial unsigned magnitude comparator controller: walks A/B MSB-first through a
// 1-bit K/L comparator cell and stops at the first differing bit.
module serial_mag_comp_ctrl #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             lt,
    output logic             eq,
    output logic [CW-1:0]    cmp_bits
);

    localparam int IW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPARE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] a_reg, a_n;
    logic [WIDTH-1:0] b_reg, b_n;
    logic [IW-1:0]    idx, idx_n;
    logic [CW-1:0]    cmp_n;
    logic             busy_n, done_n, gt_n, lt_n, eq_n;

    // 1-bit comparator cell: K = (a<=b), L = (a>=b)
    logic bit_a, bit_b, cell_k, cell_l;
    assign bit_a  = a_reg[idx];
    assign bit_b  = b_reg[idx];
    assign cell_k = ~bit_a | bit_b;
    assign cell_l = bit_a | ~bit_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            a_reg    <= '0;
            b_reg    <= '0;
            idx      <= '0;
            cmp_bits <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            gt       <= 1'b0;
            lt       <= 1'b0;
            eq       <= 1'b0;
        end else begin
            state    <= state_n;
            a_reg    <= a_n;
            b_reg    <= b_n;
            idx      <= idx_n;
            cmp_bits <= cmp_n;
            busy     <= busy_n;
            done     <= done_n;
            gt       <= gt_n;
            lt       <= lt_n;
            eq       <= eq_n;
        end
    end

    always_comb begin
        state_n = state;
        a_n     = a_reg;
        b_n     = b_reg;
        idx_n   = idx;
        cmp_n   = cmp_bits;
        busy_n  = 1'b0;
        done_n  = 1'b0;
        gt_n    = gt;
        lt_n    = lt;
        eq_n    = eq;

        case (state)
            S_IDLE: begin
                if (start) begin
                    a_n     = a;
                    b_n     = b;
                    idx_n   = IW'(WIDTH - 1);
                    cmp_n   = '0;
                    gt_n    = 1'b0;
                    lt_n    = 1'b0;
                    eq_n    = 1'b0;
                    busy_n  = 1'b1;
                    state_n = S_COMPARE;
                end
            end

            S_COMPARE: begin
                cmp_n  = cmp_bits + CW'(1);
                busy_n = 1'b1;
                // K=0,L=0 is impossible from a real cell; it falls through as "equal"
                if (!cell_k && cell_l) begin
                    gt_n    = 1'b1;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    state_n = S_DONE;
                end else if (cell_k && !cell_l) begin
                    lt_n    = 1'b1;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    state_n = S_DONE;
                end else if (idx == '0) begin
                    eq_n    = 1'b1;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    state_n = S_DONE;
                end else begin
                    idx_n = idx - IW'(1);
                end
            end

            S_DONE: begin
                state_n = S_IDLE;
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_mag_comp_ctrl.sv
// Self-checking bench for serial_mag_comp_ctrl: directed scenarios plus randomized
// operands checked against an arithmetic reference model.
module tb_serial_mag_comp_ctrl;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  a_i = '0;
    logic [W-1:0]  b_i = '0;
    logic          busy, done, gt, lt, eq;
    logic [CW-1:0] cmp_bits;

    int checks   = 0;
    int failures = 0;

    serial_mag_comp_ctrl #(.WIDTH(W), .CW(CW)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .a        (a_i),
        .b        (b_i),
        .busy     (busy),
        .done     (done),
        .gt       (gt),
        .lt       (lt),
        .eq       (eq),
        .cmp_bits (cmp_bits)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bits examined: WIDTH minus the position of the most significant differing bit.
    function automatic int model_k(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] d;
        int hi;
        d  = x ^ y;
        hi = -1;
        for (int i = 0; i < W; i++)
            if (d[i]) hi = i;
        return (hi < 0) ? W : (W - hi);
    endfunction

    // Runs one operation; a/b are replaced with av2/bv2 right after capture.
    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [W-1:0] av2, input logic [W-1:0] bv2,
                         output int busy_cnt, output int done_edge, output int done_cnt);
        a_i   = av;
        b_i   = bv;
        start = 1'b1;
        step();
        start = 1'b0;
        a_i   = av2;
        b_i   = bv2;
        busy_cnt  = 0;
        done_cnt  = 0;
        done_edge = -1;
        for (int e = 0; e < W + 4; e++) begin
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_edge < 0) done_edge = e;
            end
            step();
        end
    endtask

    task automatic test_reset();
        int pulses;
        reset = 1'b1;
        start = 1'b1;
        step();
        step();
        checks++;
        if ({busy, done, gt, lt, eq} !== 5'b0 || cmp_bits !== '0) begin
            failures++;
            $display("FAIL reset_state got busy=%b done=%b gt=%b lt=%b eq=%b cmp_bits=%0d exp all 0",
                     busy, done, gt, lt, eq, cmp_bits);
        end
        reset = 1'b0;
        start = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_start_not_latched got busy=%b exp 0", busy);
        end

        a_i   = 8'h0F;
        b_i   = 8'h0E;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL abort_busy_before got=%b exp=1", busy);
        end
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if ({busy, done, gt, lt, eq} !== 5'b0 || cmp_bits !== '0) begin
            failures++;
            $display("FAIL abort_cleared got busy=%b done=%b gt=%b lt=%b eq=%b cmp_bits=%0d exp all 0",
                     busy, done, gt, lt, eq, cmp_bits);
        end
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            if (done !== 1'b0 || busy !== 1'b0) pulses++;
            step();
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL abort_no_done got active_cycles=%0d exp 0", pulses);
        end
    endtask

    task automatic test_msb_gt();
        int bc, de, dc;
        do_op(8'h80, 8'h7F, 8'h80, 8'h7F, bc, de, dc);
        checks++;
        if (bc != 1 || de != 1 || dc != 1) begin
            failures++;
            $display("FAIL msb_gt_timing got busy=%0d done_edge=%0d pulses=%0d exp 1/1/1", bc, de, dc);
        end
        checks++;
        if ({gt, lt, eq} !== 3'b100 || cmp_bits !== CW'(1)) begin
            failures++;
            $display("FAIL msb_gt_result got gt/lt/eq=%b%b%b cmp_bits=%0d exp 100 cmp_bits=1",
                     gt, lt, eq, cmp_bits);
        end
    endtask

    task automatic test_lsb_lt();
        int bc, de, dc;
        do_op(8'h12, 8'h13, 8'h12, 8'h13, bc, de, dc);
        checks++;
        if (bc != 8 || de != 8 || dc != 1) begin
            failures++;
            $display("FAIL lsb_lt_timing got busy=%0d done_edge=%0d pulses=%0d exp 8/8/1", bc, de, dc);
        end
        checks++;
        if ({gt, lt, eq} !== 3'b010 || cmp_bits !== CW'(8)) begin
            failures++;
            $display("FAIL lsb_lt_result got gt/lt/eq=%b%b%b cmp_bits=%0d exp 010 cmp_bits=8",
                     gt, lt, eq, cmp_bits);
        end
    endtask

    task automatic test_eq_hold();
        int bc, de, dc, bad;
        do_op(8'h5A, 8'h5A, 8'h5A, 8'h5A, bc, de, dc);
        checks++;
        if (bc != 8 || de != 8 || dc != 1) begin
            failures++;
            $display("FAIL eq_timing got busy=%0d done_edge=%0d pulses=%0d exp 8/8/1", bc, de, dc);
        end
        checks++;
        if ({gt, lt, eq} !== 3'b001 || cmp_bits !== CW'(8)) begin
            failures++;
            $display("FAIL eq_result got gt/lt/eq=%b%b%b cmp_bits=%0d exp 001 cmp_bits=8",
                     gt, lt, eq, cmp_bits);
        end
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            if ({gt, lt, eq} !== 3'b001 || cmp_bits !== CW'(8) || done !== 1'b0 || busy !== 1'b0)
                bad++;
            step();
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL eq_hold got bad_cycles=%0d exp 0", bad);
        end
    endtask

    task automatic test_operand_change();
        int bc, de, dc;
        do_op(8'hA0, 8'hB0, 8'hFF, 8'h00, bc, de, dc);
        checks++;
        if (bc != 4 || de != 4 || dc != 1) begin
            failures++;
            $display("FAIL opchg_timing got busy=%0d done_edge=%0d pulses=%0d exp 4/4/1", bc, de, dc);
        end
        checks++;
        if ({gt, lt, eq} !== 3'b010 || cmp_bits !== CW'(4)) begin
            failures++;
            $display("FAIL opchg_result got gt/lt/eq=%b%b%b cmp_bits=%0d exp 010 cmp_bits=4",
                     gt, lt, eq, cmp_bits);
        end
    endtask

    task automatic test_back_to_back();
        int q[$];
        int bad;
        bad   = 0;
        a_i   = 8'h01;
        b_i   = 8'h00;
        start = 1'b1;
        for (int c = 0; c < 50; c++) begin
            step();
            if (done === 1'b1) begin
                q.push_back(c);
                if ({gt, lt, eq} !== 3'b100 || cmp_bits !== CW'(8)) bad++;
            end
        end
        start = 1'b0;
        step();
        step();
        checks++;
        if (q.size() != 5) begin
            failures++;
            $display("FAIL b2b_pulse_count got=%0d exp=5", q.size());
        end
        for (int i = 0; i < q.size(); i++) begin
            checks++;
            if (q[i] != 8 + 10 * i) begin
                failures++;
                $display("FAIL b2b_pulse_edge idx=%0d got=%0d exp=%0d", i, q[i], 8 + 10 * i);
            end
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL b2b_result got bad_pulses=%0d exp 0", bad);
        end
    endtask

    task automatic test_random();
        int bc, de, dc, k, mode;
        logic [W-1:0] av, bv;
        logic [2:0] exp_r;
        for (int n = 0; n < 30; n++) begin
            av   = W'($urandom);
            mode = $urandom_range(0, 3);
            if (mode == 0)      bv = av;
            else if (mode == 1) bv = av ^ W'(1 << $urandom_range(0, W - 1));
            else                bv = W'($urandom);
            k     = model_k(av, bv);
            exp_r = (av > bv) ? 3'b100 : (av < bv) ? 3'b010 : 3'b001;
            do_op(av, bv, W'($urandom), W'($urandom), bc, de, dc);
            checks++;
            if (bc != k || de != k || dc != 1) begin
                failures++;
                $display("FAIL rand_timing a=%0h b=%0h got busy=%0d done_edge=%0d pulses=%0d exp %0d/%0d/1",
                         av, bv, bc, de, dc, k, k);
            end
            checks++;
            if ({gt, lt, eq} !== exp_r || cmp_bits !== CW'(k)) begin
                failures++;
                $display("FAIL rand_result a=%0h b=%0h got gt/lt/eq=%b%b%b cmp_bits=%0d exp %b cmp_bits=%0d",
                         av, bv, gt, lt, eq, cmp_bits, exp_r, k);
            end
        end
    endtask

    initial begin
        test_reset();
        test_msb_gt();
        test_lsb_lt();
        test_eq_hold();
        test_operand_change();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
